// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell walked LSB-first
// over WIDTH cycles, with a held result register and overflow flag.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             s_bit, c_bit, msb;

    assign s_bit = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign c_bit = (a_sh_q[0] & b_sh_q[0]) | (b_sh_q[0] & carry_q)
                 | (a_sh_q[0] & carry_q);
    assign msb   = (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (msb) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == RUN);
        done  = (state_q == DONE);
        sum   = sum_q;
        c_out = c_out_q;
        ovf   = ovf_q;
    end

    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {s_bit, res_sh_q[WIDTH-1:1]};
                carry_d  = c_bit;
                cnt_d    = msb ? cnt_q : cnt_q + CW'(1);
                // carry_q here is still the carry into the MSB
                if (msb) begin
                    sum_d   = {s_bit, res_sh_q[WIDTH-1:1]};
                    c_out_d = c_bit;
                    ovf_d   = carry_q ^ c_bit;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH 8, 4 and 16.
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] a_in [3];
    logic [31:0] b_in [3];
    logic        cin_in [3];
    logic        start_in [3];
    wire  [31:0] sum_o [3];
    wire         cout_o [3];
    wire         ovf_o [3];
    wire         busy_o [3];
    wire         done_o [3];

    function automatic int wof(int g);
        return (g == 0) ? 8 : ((g == 1) ? 4 : 16);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int W = wof(g);
        wire [W-1:0] s;
        serial_add_ctrl #(.WIDTH(W)) dut (
            .clk   (clk),
            .rst   (rst),
            .start (start_in[g]),
            .a     (a_in[g][W-1:0]),
            .b     (b_in[g][W-1:0]),
            .c_in  (cin_in[g]),
            .busy  (busy_o[g]),
            .done  (done_o[g]),
            .sum   (s),
            .c_out (cout_o[g]),
            .ovf   (ovf_o[g])
        );
        assign sum_o[g] = 32'(s);
    end

    typedef struct {
        int          g;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [33:0] held [3];
    int          bcnt [3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer addition, overflow from operand/result signs
    task automatic push(int g, logic [31:0] a, logic [31:0] b, logic c);
        int                w = wof(g);
        longint unsigned   m = (longint'(1) << w) - 1;
        longint unsigned   full;
        exp_t              e;
        logic              sa, sb, ss;
        full   = (longint'(a) & m) + (longint'(b) & m) + longint'(c);
        e.g    = g;
        e.sum  = 32'(full & m);
        e.cout = ((full >> w) & 1) != 0;
        sa     = a[w-1];
        sb     = b[w-1];
        ss     = e.sum[w-1];
        e.ovf  = (sa == sb) && (ss != sa);
        e.cyc  = cyc + w;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                held[k] = '0;
                bcnt[k] = 0;
            end else begin
                chk("busy_done_excl", 64'(busy_o[k] & done_o[k]), 0);
                if (busy_o[k]) bcnt[k]++;
                if (done_o[k]) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", q.size(), 1);
                    end else begin
                        mon_e = q.pop_front();
                        chk("dut_index", k, mon_e.g);
                        chk("sum", sum_o[k], mon_e.sum);
                        chk("c_out", 64'(cout_o[k]), 64'(mon_e.cout));
                        chk("ovf", 64'(ovf_o[k]), 64'(mon_e.ovf));
                        chk("done_cycle", cyc, mon_e.cyc);
                        chk("busy_cycles", bcnt[k], wof(k));
                    end
                    held[k] = {cout_o[k], ovf_o[k], sum_o[k]};
                    bcnt[k] = 0;
                end else begin
                    chk("hold", {cout_o[k], ovf_o[k], sum_o[k]}, held[k]);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
        chk("done_timeout", q.size(), 0);
        q.delete();
        #1;
    endtask

    task automatic issue(int g, logic [31:0] a, logic [31:0] b,
                         logic c, bit expect_result);
        a_in[g]     = a;
        b_in[g]     = b;
        cin_in[g]   = c;
        start_in[g] = 1'b1;
        @(posedge clk);
        #1;
        if (expect_result) push(g, a, b, c);
        start_in[g] = 1'b0;
        a_in[g]     = $urandom;
        b_in[g]     = $urandom;
        cin_in[g]   = 1'($urandom);
    endtask

    task automatic b2b(int g, int n);
        logic [31:0] a, b;
        logic        c;
        start_in[g] = 1'b1;
        for (int k = 0; k < n; k++) begin
            a = $urandom;
            b = $urandom;
            c = 1'($urandom);
            a_in[g]   = a;
            b_in[g]   = b;
            cin_in[g] = c;
            @(posedge clk);
            #1;
            push(g, a, b, c);
            a_in[g]   = $urandom;
            b_in[g]   = $urandom;
            cin_in[g] = 1'($urandom);
            if (k != n - 1) begin
                repeat (wof(g) + 1) @(posedge clk);
                #1;
            end
        end
        start_in[g] = 1'b0;
        wait_idle();
    endtask

    task automatic chk_zero(string nm, int g);
        chk(nm, {busy_o[g], done_o[g], cout_o[g], ovf_o[g], sum_o[g]}, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            a_in[g] = '0;
            b_in[g] = '0;
            cin_in[g] = 1'b0;
            start_in[g] = 1'b0;
        end
        #3;
        for (int g = 0; g < 3; g++) chk_zero("reset_state", g);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(0, 32'h3C, 32'h21, 1'b0, 1'b1);
        wait_idle();
        issue(0, 32'hFF, 32'h00, 1'b1, 1'b1);
        wait_idle();
        issue(0, 32'h7F, 32'h01, 1'b0, 1'b1);
        wait_idle();
        issue(0, 32'h80, 32'h80, 1'b0, 1'b1);
        wait_idle();

        issue(0, 32'h11, 32'h22, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        a_in[0] = 32'h55;
        b_in[0] = 32'h66;
        start_in[0] = 1'b1;
        @(posedge clk);
        #1;
        start_in[0] = 1'b0;
        wait_idle();

        issue(0, 32'hA5, 32'h5A, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("reset_abort", 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(0, 32'h01, 32'h01, 1'b0, 1'b1);
        wait_idle();
        b2b(0, 6);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    issue(1, 32'(a), 32'(b), 1'(c), 1'b1);
                    wait_idle();
                end
        b2b(1, 20);

        issue(2, 32'hFFFF, 32'h0000, 1'b1, 1'b1);
        wait_idle();
        issue(2, 32'h7FFF, 32'h0001, 1'b0, 1'b1);
        wait_idle();
        repeat (150) begin
            issue(2, $urandom, $urandom, 1'($urandom), 1'b1);
            wait_idle();
        end
        b2b(2, 30);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A; captured on the accepted start.
REQ-006 Port: b  input  WIDTH  operand B; captured on the accepted start.
REQ-007 Port: c_in  input  1  carry-in; captured on the accepted start.
REQ-008 Port: busy  output  1  high while an addition is in progress (RUN state).
REQ-009 Port: done  output  1  single-cycle pulse when the result is valid.
REQ-010 Port: sum  output  WIDTH  result; held stable from done until the next accepted start.
REQ-011 Port: c_out  output  1  carry out of the MSB; held with sum.
REQ-012 Port: ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB); held with sum.

Function
REQ-013 The block SHALL sequence one 1-bit full-adder cell (sum = a^b^c, carry = ab|bc|ac) LSB-first over WIDTH cycles; no WIDTH-wide adder.
REQ-014 FSM states SHALL be IDLE, RUN, DONE; encoding free.
REQ-015 IDLE: start=1 -> capture a, b, c_in into shift registers/carry flop, clear bit counter to 0, go RUN; start=0 -> stay IDLE.
REQ-016 RUN: each cycle add the current LSBs of the A/B shift registers and the carry flop, shift the result bit into the sum register from the MSB side, shift A/B right, update carry, increment counter.
REQ-017 RUN -> DONE on the cycle the counter equals WIDTH-1 (the MSB cycle); exactly WIDTH RUN cycles per operation.
REQ-018 On the MSB cycle the carry into the MSB SHALL be saved for ovf before the carry flop updates.
REQ-019 DONE lasts exactly one cycle with done=1, then returns to IDLE unconditionally.
REQ-020 Latency: start accepted at edge N -> done high in the cycle following edge N+WIDTH; throughput one result per WIDTH+2 cycles.
REQ-021 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE; never both high.
REQ-022 start during RUN or DONE SHALL be ignored (not queued); a, b, c_in changes outside the accept cycle SHALL have no effect.
REQ-023 The bit counter SHALL be wide enough for WIDTH-1 and SHALL NOT wrap within an operation; reset to 0 on each accept.
REQ-024 sum, c_out, ovf SHALL update only when the DONE state is entered; during RUN they show the previous result (internal shift register is separate from sum output register).
REQ-025 Arithmetic SHALL be modulo 2^WIDTH; c_out is the 2^WIDTH bit.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, busy=0, done=0, sum=0, c_out=0, ovf=0, and clear the counter, shift registers and carry flop, regardless of clk.
REQ-027 rst asserted mid-RUN SHALL abort the operation with no done pulse; after release the block waits for a new start.
REQ-028 start high in the first cycle after rst deasserts SHALL be accepted normally.

Verification
REQ-029 WIDTH=8: a=0x3C, b=0x21, c_in=0 -> done after 8 busy cycles, sum=0x5D, c_out=0, ovf=0.
REQ-030 WIDTH=8: a=0xFF, b=0x00, c_in=1 -> sum=0x00, c_out=1, ovf=0 (full carry ripple).
REQ-031 WIDTH=8: a=0x7F, b=0x01, c_in=0 -> sum=0x80, c_out=0, ovf=1; a=0x80, b=0x80 -> sum=0x00, c_out=1, ovf=1.
REQ-032 Start with a=0x11, b=0x22, re-pulse start with different operands at RUN cycle 3 -> ignored; result sum=0x33; busy exactly 8 cycles.
REQ-033 rst asserted at RUN cycle 4 -> outputs zero at once, no done; subsequent start with a=0x01, b=0x01 -> sum=0x02.
REQ-034 Random regression, WIDTH=4 exhaustive and WIDTH=16 random: {c_out,sum} == a+b+c_in, ovf matches signed overflow, back-to-back starts held high -> one result per WIDTH+2 cycles.
